// File: rtl/calc_result_display_pkg.sv
// Shared types and constants for the calculator result display path:
// converter FSM states, 7-segment codes and the double-dabble nibble adjust.
package calc_disp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  // Segment order {g,f,e,d,c,b,a}, active-low (common-anode display)
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;

  // Double-dabble correction: every BCD nibble of 5 or more gets +3 before the shift
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int i = 0; i < 4; i++) begin
      if (b[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = b[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/calc_result_display_bcd_to_7seg.sv
// Combinational BCD digit to active-low 7-segment pattern; non-decimal codes blank.
module bcd_to_7seg
  import calc_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/calc_result_display.sv
// Captures the adder result, converts it to BCD with a sequential double-dabble
// and scans up to four digits onto a common-anode 7-segment display.
module calc_result_display
  import calc_disp_pkg::*;
#(
  parameter int DATA_W      = 5,
  parameter int REFRESH_DIV = 100000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] data,
  output logic              busy,
  output logic              bcd_valid,
  output logic [6:0]        seg,
  output logic [3:0]        an
);

  localparam int CNT_W  = $clog2(DATA_W + 1);
  localparam int RCNT_W = $clog2(REFRESH_DIV);
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DATA_W - 1);
  localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REFRESH_DIV - 1);

  state_t state, state_nx;

  logic [DATA_W-1:0] shreg;
  logic [15:0]       bcd;
  logic [15:0]       bcd_adj;
  logic [15:0]       disp;
  logic [CNT_W-1:0]  cnt;
  logic              pend;
  logic [DATA_W-1:0] pend_data;

  logic              start;
  logic [DATA_W-1:0] start_data;
  logic              iter;
  logic              finish;

  logic [RCNT_W-1:0] rcnt;
  logic [1:0]        idx;
  logic [3:0]        cur_digit;
  logic              blank;
  logic [6:0]        enc_seg;

  assign bcd_adj = dd_adjust(bcd);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // A load seen in DONE is the freshest value, so it beats anything already pending
  always_comb begin
    state_nx   = state;
    start      = 1'b0;
    start_data = data;
    iter       = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (load) begin
          start    = 1'b1;
          state_nx = CONV;
        end
      end
      CONV: begin
        iter = 1'b1;
        if (cnt == CNT_LAST) state_nx = DONE;
      end
      DONE: begin
        finish = 1'b1;
        if (load) begin
          start    = 1'b1;
          state_nx = CONV;
        end else if (pend) begin
          start      = 1'b1;
          start_data = pend_data;
          state_nx   = CONV;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend      <= 1'b0;
      pend_data <= '0;
    end else if (state == DONE) begin
      pend <= 1'b0;
    end else if (state == CONV && load) begin
      pend      <= 1'b1;
      pend_data <= data;
    end
  end

  // Shift register and BCD accumulator; the display copy only moves on finish
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg     <= '0;
      bcd       <= '0;
      cnt       <= '0;
      disp      <= '0;
      busy      <= 1'b0;
      bcd_valid <= 1'b0;
    end else begin
      busy      <= (state_nx != IDLE);
      bcd_valid <= finish;
      if (finish) disp <= bcd;
      if (start) begin
        shreg <= start_data;
        bcd   <= '0;
        cnt   <= '0;
      end else if (iter) begin
        shreg <= shreg << 1;
        bcd   <= (bcd_adj << 1) | 16'(shreg[DATA_W-1]);
        cnt   <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt <= '0;
      idx  <= '0;
    end else if (rcnt == RCNT_LAST) begin
      rcnt <= '0;
      idx  <= idx + 2'd1;
    end else begin
      rcnt <= rcnt + 1'b1;
    end
  end

  // A digit is blank when it and every digit above it is zero; the ones digit always shows
  always_comb begin
    cur_digit = disp[3:0];
    blank     = 1'b0;
    case (idx)
      2'd0: begin
        cur_digit = disp[3:0];
        blank     = 1'b0;
      end
      2'd1: begin
        cur_digit = disp[7:4];
        blank     = (disp[15:4] == 12'd0);
      end
      2'd2: begin
        cur_digit = disp[11:8];
        blank     = (disp[15:8] == 8'd0);
      end
      2'd3: begin
        cur_digit = disp[15:12];
        blank     = (disp[15:12] == 4'd0);
      end
      default: begin
        cur_digit = disp[3:0];
        blank     = 1'b0;
      end
    endcase
  end

  bcd_to_7seg u_enc (
    .bcd (cur_digit),
    .seg (enc_seg)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg <= SEG_BLANK;
      an  <= 4'hF;
    end else begin
      seg <= blank ? SEG_BLANK : enc_seg;
      an  <= ~(4'b0001 << idx);
    end
  end

endmodule

// File: tb/tb_calc_result_display.sv
// Directed self-checking bench for calc_result_display with a fast refresh divider
// so the full digit scan fits in a handful of cycles.
module tb_calc_result_display;

  logic       clk;
  logic       reset;
  logic       load;
  logic [4:0] data;
  logic       busy;
  logic       bcd_valid;
  logic [6:0] seg;
  logic [3:0] an;

  int compared;
  int mismatched;

  logic [6:0] dig [4];
  logic       badAn;
  int         lat;
  logic       busyOk;
  logic       sawValid;
  logic       sawBusy;
  logic [3:0] scanSeq [5];
  logic [3:0] prevAn;
  int         hold;
  int         guard;

  calc_result_display #(
    .DATA_W      (5),
    .REFRESH_DIV (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .data      (data),
    .busy      (busy),
    .bcd_valid (bcd_valid),
    .seg       (seg),
    .an        (an)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Hand-written segment table, independent of the design package
  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  function automatic logic [6:0] expSeg(input int v, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    if (k > 0 && v < p) return 7'h7F;
    return segOf((v / p) % 10);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [4:0] d);
    @(negedge clk);
    load = 1'b1;
    data = d;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Sample enough cycles to see every anode once and record the segment pattern per digit
  task automatic captureDigits();
    for (int i = 0; i < 4; i++) dig[i] = 7'bx;
    badAn = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      case (an)
        4'b1110: dig[0] = seg;
        4'b1101: dig[1] = seg;
        4'b1011: dig[2] = seg;
        4'b0111: dig[3] = seg;
        default: badAn = 1'b1;
      endcase
    end
  endtask

  // Count rising edges until bcd_valid shows, noting whether busy held high meanwhile
  task automatic waitValid(output int n, output logic bOk);
    n   = 0;
    bOk = 1'b1;
    while (!bcd_valid && n < 50) begin
      if (!busy) bOk = 1'b0;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    load       = 1'b0;
    data       = 5'd0;

    // Reset held: outputs in their idle values
    repeat (3) @(negedge clk);
    checkOutput("rst_seg", 32'(seg), 32'h7F);
    checkOutput("rst_an", 32'(an), 32'hF);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_valid", 32'(bcd_valid), 32'd0);
    reset = 1'b0;

    // After release the scan shows a lone "0"
    captureDigits();
    checkOutput("init_d0", 32'(dig[0]), 32'h40);
    checkOutput("init_d1", 32'(dig[1]), 32'h7F);
    checkOutput("init_d2", 32'(dig[2]), 32'h7F);
    checkOutput("init_d3", 32'(dig[3]), 32'h7F);
    checkOutput("init_an_legal", 32'(badAn), 32'd0);
    checkOutput("init_busy", 32'(busy), 32'd0);

    // Refresh scan order and dwell time
    scanSeq[0] = 4'b1110;
    scanSeq[1] = 4'b1101;
    scanSeq[2] = 4'b1011;
    scanSeq[3] = 4'b0111;
    scanSeq[4] = 4'b1110;
    prevAn = an;
    guard  = 0;
    @(negedge clk);
    while (!(an == 4'b1110 && prevAn != 4'b1110) && guard < 30) begin
      prevAn = an;
      @(negedge clk);
      guard++;
    end
    for (int k = 0; k < 5; k++) begin
      checkOutput($sformatf("scan_an%0d", k), 32'(an), 32'(scanSeq[k]));
      if (k < 4) begin
        hold = 0;
        while (an == scanSeq[k] && hold < 10) begin
          @(negedge clk);
          hold++;
        end
        checkOutput($sformatf("scan_hold%0d", k), 32'(hold), 32'd4);
      end
    end

    // Convert 31: latency, busy window, one-cycle valid pulse, "31" on display
    applyStimulus(5'd31);
    checkOutput("l31_busy_start", 32'(busy), 32'd1);
    waitValid(lat, busyOk);
    checkOutput("l31_latency", 32'(lat), 32'd6);
    checkOutput("l31_busy_held", 32'(busyOk), 32'd1);
    checkOutput("l31_busy_done", 32'(busy), 32'd0);
    @(negedge clk);
    checkOutput("l31_valid_pulse", 32'(bcd_valid), 32'd0);
    captureDigits();
    checkOutput("l31_d0", 32'(dig[0]), 32'h79);
    checkOutput("l31_d1", 32'(dig[1]), 32'h30);
    checkOutput("l31_d2", 32'(dig[2]), 32'h7F);
    checkOutput("l31_d3", 32'(dig[3]), 32'h7F);

    // Load 9, then 17 while busy: second conversion chains straight on
    applyStimulus(5'd9);
    @(negedge clk);
    load = 1'b1;
    data = 5'd17;
    @(negedge clk);
    load = 1'b0;
    waitValid(lat, busyOk);
    checkOutput("pend_first_lat", 32'(lat), 32'd4);
    checkOutput("pend_busy_stays", 32'(busy), 32'd1);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (!busy && !bcd_valid) busyOk = 1'b0;
    end while (!bcd_valid && lat < 50);
    checkOutput("pend_second_lat", 32'(lat), 32'd6);
    checkOutput("pend_busy_held", 32'(busyOk), 32'd1);
    checkOutput("pend_busy_done", 32'(busy), 32'd0);
    captureDigits();
    checkOutput("l17_d0", 32'(dig[0]), 32'h78);
    checkOutput("l17_d1", 32'(dig[1]), 32'h79);
    checkOutput("l17_d2", 32'(dig[2]), 32'h7F);
    checkOutput("l17_d3", 32'(dig[3]), 32'h7F);

    // Reset in the middle of converting 20
    applyStimulus(5'd20);
    @(negedge clk);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_seg", 32'(seg), 32'h7F);
    checkOutput("midrst_an", 32'(an), 32'hF);
    checkOutput("midrst_valid", 32'(bcd_valid), 32'd0);
    @(negedge clk);
    reset    = 1'b0;
    sawValid = 1'b0;
    sawBusy  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bcd_valid) sawValid = 1'b1;
      if (busy) sawBusy = 1'b1;
    end
    checkOutput("midrst_no_valid", 32'(sawValid), 32'd0);
    checkOutput("midrst_no_busy", 32'(sawBusy), 32'd0);
    captureDigits();
    checkOutput("midrst_d0", 32'(dig[0]), 32'h40);
    checkOutput("midrst_d1", 32'(dig[1]), 32'h7F);
    checkOutput("midrst_d2", 32'(dig[2]), 32'h7F);
    checkOutput("midrst_d3", 32'(dig[3]), 32'h7F);

    // Every 5-bit value: latency and the decimal digits with blanking
    for (int v = 0; v < 32; v++) begin
      applyStimulus(5'(v));
      waitValid(lat, busyOk);
      checkOutput($sformatf("ex%0d_latency", v), 32'(lat), 32'd6);
      captureDigits();
      for (int k = 0; k < 4; k++) begin
        checkOutput($sformatf("ex%0d_d%0d", v, k), 32'(dig[k]), 32'(expSeg(v, k)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
